// File: rtl/mux_onehot_demux_1to4_if.sv
// Bundles the input stream, the four output channels and the drop status
// of the 1-to-4 one-hot demultiplexer.
interface mux_onehot_demux_1to4_if #(
  parameter int WIDTH = 32
);
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_bits;
  logic [3:0]       io_in_sel;

  logic             io_out0_valid;
  logic             io_out0_ready;
  logic [WIDTH-1:0] io_out0_bits;
  logic             io_out1_valid;
  logic             io_out1_ready;
  logic [WIDTH-1:0] io_out1_bits;
  logic             io_out2_valid;
  logic             io_out2_ready;
  logic [WIDTH-1:0] io_out2_bits;
  logic             io_out3_valid;
  logic             io_out3_ready;
  logic [WIDTH-1:0] io_out3_bits;

  logic             io_err;
  logic [7:0]       io_drop_cnt;

  // The producer of the input stream and consumer of all four channels.
  modport master (
    output io_in_valid, io_in_bits, io_in_sel,
    output io_out0_ready, io_out1_ready, io_out2_ready, io_out3_ready,
    input  io_in_ready,
    input  io_out0_valid, io_out0_bits, io_out1_valid, io_out1_bits,
    input  io_out2_valid, io_out2_bits, io_out3_valid, io_out3_bits,
    input  io_err, io_drop_cnt
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_in_sel,
    input  io_out0_ready, io_out1_ready, io_out2_ready, io_out3_ready,
    output io_in_ready,
    output io_out0_valid, io_out0_bits, io_out1_valid, io_out1_bits,
    output io_out2_valid, io_out2_bits, io_out3_valid, io_out3_bits,
    output io_err, io_drop_cnt
  );
endinterface

// File: rtl/mux_onehot_demux_1to4.sv
// Buffered 1-to-4 one-hot demultiplexer: one register slot per channel,
// malformed selects are accepted, dropped, flagged and counted.
module mux_onehot_demux_1to4 #(
  parameter int WIDTH = 32
) (
  input logic                   clock,
  input logic                   reset,
  mux_onehot_demux_1to4_if.slave io
);

  logic [3:0]       r_full;
  logic [WIDTH-1:0] r_data [4];
  logic             r_err;
  logic [7:0]       r_dropCnt;

  logic [3:0]       w_outReady;
  logic             w_selOk;
  logic             w_inReady;
  logic             w_accept;

  assign w_outReady = {io.io_out3_ready, io.io_out2_ready,
                       io.io_out1_ready, io.io_out0_ready};

  assign w_selOk = (io.io_in_sel != 4'd0) &&
                   ((io.io_in_sel & (io.io_in_sel - 4'd1)) == 4'd0);

  // A malformed beat is always taken so it cannot wedge the stream; a good
  // beat waits only on the slot it targets, which may drain this same cycle.
  always_comb begin
    w_inReady = 1'b1;
    if (w_selOk) begin
      w_inReady = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (io.io_in_sel[k]) begin
          w_inReady = !r_full[k] || w_outReady[k];
        end
      end
    end
  end

  assign w_accept = io.io_in_valid && w_inReady;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_full    <= 4'd0;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
      r_err     <= 1'b0;
      r_dropCnt <= 8'd0;
    end else begin
      // Loading wins over draining so drain-and-load keeps the slot full.
      for (int k = 0; k < 4; k++) begin
        if (w_accept && w_selOk && io.io_in_sel[k]) begin
          r_data[k] <= io.io_in_bits;
          r_full[k] <= 1'b1;
        end else if (r_full[k] && w_outReady[k]) begin
          r_full[k] <= 1'b0;
        end
      end
      r_err <= w_accept && !w_selOk;
      if (w_accept && !w_selOk && (r_dropCnt != 8'hFF)) begin
        r_dropCnt <= r_dropCnt + 8'd1;
      end
    end
  end

  assign io.io_in_ready   = w_inReady;
  assign io.io_out0_valid = r_full[0];
  assign io.io_out1_valid = r_full[1];
  assign io.io_out2_valid = r_full[2];
  assign io.io_out3_valid = r_full[3];
  assign io.io_out0_bits  = r_data[0];
  assign io.io_out1_bits  = r_data[1];
  assign io.io_out2_bits  = r_data[2];
  assign io.io_out3_bits  = r_data[3];
  assign io.io_err        = r_err;
  assign io.io_drop_cnt   = r_dropCnt;

endmodule

// File: tb/tb_mux_onehot_demux_1to4.sv
// Scoreboard bench: accepted beats are queued per channel, and a negedge
// monitor checks every presented output word against its channel queue.
module tb_mux_onehot_demux_1to4;

  localparam int WIDTH = 32;

  logic clock;
  logic reset;

  mux_onehot_demux_1to4_if #(.WIDTH(WIDTH)) busIf ();

  mux_onehot_demux_1to4 #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .io    (busIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int testCount = 0;
  int failCount = 0;
  logic [WIDTH-1:0] expQ [4][$];

  logic [3:0]       outValid;
  logic [3:0]       outReady;
  logic [WIDTH-1:0] outBits [4];

  assign outValid = {busIf.io_out3_valid, busIf.io_out2_valid,
                     busIf.io_out1_valid, busIf.io_out0_valid};
  assign outReady = {busIf.io_out3_ready, busIf.io_out2_ready,
                     busIf.io_out1_ready, busIf.io_out0_ready};
  assign outBits[0] = busIf.io_out0_bits;
  assign outBits[1] = busIf.io_out1_bits;
  assign outBits[2] = busIf.io_out2_bits;
  assign outBits[3] = busIf.io_out3_bits;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data,
                               input logic [3:0] sel, input logic [3:0] readies);
    busIf.io_in_valid   = valid;
    busIf.io_in_bits    = data;
    busIf.io_in_sel     = sel;
    busIf.io_out0_ready = readies[0];
    busIf.io_out1_ready = readies[1];
    busIf.io_out2_ready = readies[2];
    busIf.io_out3_ready = readies[3];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one beat for one cycle; a beat expected to be taken with a good
  // select is queued as the future content of its channel.
  task automatic issueBeat(input logic [WIDTH-1:0] data, input logic [3:0] sel,
                           input logic [3:0] readies, input logic expReady);
    applyStimulus(1'b1, data, sel, readies);
    if (expReady && (sel == 4'd1 || sel == 4'd2 || sel == 4'd4 || sel == 4'd8)) begin
      for (int k = 0; k < 4; k++) begin
        if (sel[k]) expQ[k].push_back(data);
      end
    end
    @(negedge clock);
    checkOutput($sformatf("in_ready data=0x%0h sel=%b", data, sel),
                {31'd0, busIf.io_in_ready}, {31'd0, expReady});
    tick();
  endtask

  // Monitor: any valid word must be the head of its channel queue; it is
  // consumed when the channel ready is high at the next rising edge.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 4; k++) begin
        if (outValid[k] === 1'b1) begin
          if (expQ[k].size() == 0) begin
            checkOutput($sformatf("unexpected out%0d", k), outBits[k], 32'hDEAD_BEEF);
          end else begin
            checkOutput($sformatf("out%0d bits", k), outBits[k], expQ[k][0]);
            if (outReady[k]) void'(expQ[k].pop_front());
          end
        end
      end
    end
  end

  initial begin
    // Reset held two cycles while a good beat is offered
    reset = 1'b1;
    applyStimulus(1'b1, 32'hEE, 4'b0001, 4'hF);
    tick();
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    checkOutput("reset valids", {28'd0, outValid}, 32'h0);
    checkOutput("reset err", {31'd0, busIf.io_err}, 32'h0);
    checkOutput("reset drop_cnt", {24'd0, busIf.io_drop_cnt}, 32'h0);
    tick();
    checkOutput("post-reset valids", {28'd0, outValid}, 32'h0);

    // Routing: one beat per channel on consecutive cycles
    issueBeat(32'hA0, 4'b0001, 4'hF, 1'b1);
    checkOutput("route valid0", {28'd0, outValid}, 32'h1);
    issueBeat(32'hB1, 4'b0010, 4'hF, 1'b1);
    checkOutput("route valid1", {28'd0, outValid}, 32'h2);
    issueBeat(32'hC2, 4'b0100, 4'hF, 1'b1);
    checkOutput("route valid2", {28'd0, outValid}, 32'h4);
    issueBeat(32'hD3, 4'b1000, 4'hF, 1'b1);
    checkOutput("route valid3", {28'd0, outValid}, 32'h8);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();
    checkOutput("route drained", {28'd0, outValid}, 32'h0);

    // Back-pressure on channel 2; 0x33 waits behind the stalled head beat
    issueBeat(32'h11, 4'b0100, 4'b1011, 1'b1);
    issueBeat(32'h22, 4'b0100, 4'b1011, 1'b0);
    issueBeat(32'h22, 4'b0100, 4'b1011, 1'b0);
    checkOutput("bp held valid", {28'd0, outValid}, 32'h4);
    checkOutput("bp held bits", busIf.io_out2_bits, 32'h11);
    issueBeat(32'h22, 4'b0100, 4'hF, 1'b1);
    checkOutput("bp new bits", busIf.io_out2_bits, 32'h22);
    issueBeat(32'h33, 4'b0001, 4'hF, 1'b1);
    checkOutput("bp 0x33 valid", {28'd0, outValid}, 32'h1);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();

    // Drain-and-load on channel 0 with no bubble
    issueBeat(32'h5, 4'b0001, 4'hF, 1'b1);
    issueBeat(32'h6, 4'b0001, 4'hF, 1'b1);
    checkOutput("dl valid0", {31'd0, busIf.io_out0_valid}, 32'h1);
    checkOutput("dl bits0", busIf.io_out0_bits, 32'h6);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();

    // Malformed selects: accepted, dropped, flagged, counted
    issueBeat(32'h91, 4'b0000, 4'hF, 1'b1);
    checkOutput("drop1 err", {31'd0, busIf.io_err}, 32'h1);
    issueBeat(32'h92, 4'b0011, 4'hF, 1'b1);
    checkOutput("drop2 err", {31'd0, busIf.io_err}, 32'h1);
    issueBeat(32'h93, 4'b1111, 4'hF, 1'b1);
    checkOutput("drop3 err", {31'd0, busIf.io_err}, 32'h1);
    checkOutput("drop3 cnt", {24'd0, busIf.io_drop_cnt}, 32'd3);
    checkOutput("drop no valid", {28'd0, outValid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();
    checkOutput("err cleared", {31'd0, busIf.io_err}, 32'h0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 32'(i), 4'b0110, 4'hF);
      tick();
      if (i == 251) checkOutput("cnt reaches 255", {24'd0, busIf.io_drop_cnt}, 32'd255);
    end
    checkOutput("cnt saturated", {24'd0, busIf.io_drop_cnt}, 32'd255);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();

    // Mid-operation reset discards all four buffered beats
    issueBeat(32'h71, 4'b0001, 4'h0, 1'b1);
    issueBeat(32'h72, 4'b0010, 4'h0, 1'b1);
    issueBeat(32'h74, 4'b0100, 4'h0, 1'b1);
    issueBeat(32'h78, 4'b1000, 4'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'h0);
    checkOutput("all slots full", {28'd0, outValid}, 32'hF);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) expQ[k].delete();
    tick();
    reset = 1'b0;
    checkOutput("mid reset valids", {28'd0, outValid}, 32'h0);
    checkOutput("mid reset cnt", {24'd0, busIf.io_drop_cnt}, 32'h0);
    applyStimulus(1'b0, 32'h0, 4'b0000, 4'hF);
    tick();
    tick();
    checkOutput("no stale data", {28'd0, outValid}, 32'h0);

    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("queue%0d empty", k), 32'(expQ[k].size()), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/mux_onehot_demux_1to4.md
# mux_onehot_demux_1to4

Buffered 1-to-4 one-hot demultiplexer: it steers a valid/ready input stream to one of four output channels selected by a one-hot code. It is the fan-out counterpart of the 4-to-1 one-hot mux in the same datapath. Each output channel has a one-entry register slot, so channels drain independently with 1-cycle latency. Malformed selects (zero or multiple bits set) are dropped, flagged and counted.

## Interface
- WIDTH, 32, data width of input and output bits.
- clock  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  input beat present.
- io_in_ready  output  1  input beat accepted this cycle when high together with io_in_valid.
- io_in_bits  input  WIDTH  input data.
- io_in_sel  input  4  one-hot destination; bit k selects channel k; sampled with the beat.
- io_outN_valid  output  1  (N=0..3) channel N slot holds data.
- io_outN_ready  input  1  (N=0..3) consumer on channel N takes data.
- io_outN_bits  output  WIDTH  (N=0..3) channel N slot data.
- io_err  output  1  one-cycle pulse: a malformed-select beat was dropped on the previous cycle.
- io_drop_cnt  output  8  saturating count of dropped beats.

## Operation
- sel_ok = io_in_sel has exactly one bit set (values 1, 2, 4, 8).
- Per channel k: registers full_k, data_k; io_outk_valid = full_k; io_outk_bits = data_k.
- io_in_ready (combinational from io_in_sel and slot state):
  - sel_ok and sel bit k set: ready = !full_k || io_outk_ready.
  - !sel_ok: ready = 1 (beat is always accepted, then dropped).
- Accept = io_in_valid && io_in_ready.
- Slot k update, evaluated in priority order:
  - Accept with sel_ok targeting k: data_k <= io_in_bits, full_k <= 1. This covers drain-and-load in the same cycle; the slot stays full with the new data.
  - Otherwise, full_k && io_outk_ready: full_k <= 0, data_k held.
  - Otherwise: hold.
- Non-targeted slots are unaffected by the accept and drain on their own ready.
- Drop path: Accept with !sel_ok sets io_err <= 1 for exactly the next cycle. io_drop_cnt <= io_drop_cnt + 1, saturating at 255. No slot changes.
- Ordering: beats to the same channel leave in acceptance order. Ordering across channels is not defined.
- A blocked channel stalls the input only while the head beat targets that channel; there is no internal queueing beyond one entry per channel.
- io_in_bits and io_in_sel need not be stable while io_in_ready is low; only the accept cycle matters.

## Timing
- Latency: beat accepted in cycle t appears on io_outk_valid/bits in cycle t+1.
- Throughput: 1 beat/cycle to any channel, including back-to-back beats to the same channel while its consumer holds ready high.
- Reset (synchronous, checked at the clock edge):
  - full_k = 0, data_k = 0, io_err = 0, io_drop_cnt = 0.
  - All io_outN_valid = 0 in the cycle after reset is sampled high.
- Reset mid-operation: buffered data is discarded and not delivered. io_in_ready still evaluates combinationally during reset, but no accept during reset changes state.
- io_err is a registered pulse: high in cycle t+1 only, for a drop in cycle t. Consecutive drops give a continuous high.
- io_drop_cnt is registered and updates in cycle t+1.
- No combinational path from io_outN_ready to io_outN_valid/bits. A combinational path from io_outk_ready and io_in_sel to io_in_ready is permitted.

## Test plan
- **Reset:** assert reset 2 cycles with io_in_valid=1, sel=4'b0001 -> all io_outN_valid=0, io_drop_cnt=0, io_err=0 after reset releases.
- **Routing:** send 0xA0, 0xB1, 0xC2, 0xD3 with sel 1, 2, 4, 8 on consecutive cycles, all out ready=1 -> each io_outN_valid pulses 1 cycle later with matching bits on channel N only; io_in_ready stays 1 throughout.
- **Back-pressure:** io_out2_ready=0; send 0x11 then 0x22 to sel=4 -> 0x11 held on io_out2_bits, io_in_ready=0 for the 0x22 beat. Meanwhile a 0x33 beat to sel=1 is still not taken because it queues behind the head beat. Raise io_out2_ready -> 0x22 accepted the same cycle and visible next cycle.
- **Drain-and-load:** channel 0 full with 0x5, io_out0_ready=1, new beat 0x6 sel=1 -> io_in_ready=1, and the next cycle shows io_out0_valid=1, bits=0x6 with no bubble.
- **Malformed select:** send beats with sel 0, 4'b0011, 4'b1111 -> each accepted, no output valid, io_err high 3 cycles, io_drop_cnt=3. Then drive 300 malformed beats -> io_drop_cnt saturates at 255.
- **Mid-operation reset:** all four slots full with out ready=0, then assert reset 1 cycle -> all valids 0 next cycle and no stale data delivered after ready rises.
